embed_ram_streamer: RTL and testbench

Downstream read stage of the patch-embedding block: once the Embedded RAM holds a complete embedded frame, this block sweeps its read port from address 0 to `NUM_WORDS-1`. It can replay the frame once per spiking time-step. The block absorbs the RAM's fixed 2-cycle read latency with a credit-limited skid FIFO and presents the words as a valid/ready stream to the attention/QKV stage. Backpressure from the consumer never drops or duplicates a word.

---
 rtl/embed_ram_streamer.sv | 192 +++++++++++++++++++
 tb/tb_embed_ram_streamer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/embed_ram_streamer.sv
// embed_ram_streamer
//   Sweeps the Embedded RAM read port over one complete frame (address 0 to
//   NUM_WORDS-1), optionally replaying the frame several times. The RAM's
//   fixed read latency is absorbed by a credit-limited skid FIFO, and the
//   words are presented to the consumer as a valid/ready stream.
//
// Ports
//   s_clk, s_rst     clock, asynchronous active-high reset
//   i_start          single-cycle start pulse (accepted only when idle)
//   i_passes         replay count sampled on start (0 treated as 1)
//   i_ram_ready      frame-complete flag from the embed stage
//   o_rd_addr        registered RAM read address
//   i_ram_data       RAM read data, valid RD_LAT cycles after the address
//   o_data/o_valid   stream word / valid, driven from the FIFO head
//   i_ready          consumer ready
//   o_last           last word of a pass
//   o_pass_idx       pass number of the head word
//   o_busy           high whenever not idle
//   o_done           one-cycle pulse after the final word is accepted
module embed_ram_streamer #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 12,
    parameter int NUM_WORDS  = 1024,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_start,
    input  logic [3:0]        i_passes,
    input  logic              i_ram_ready,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_ram_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic [3:0]        o_pass_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [1:0] ST_ISSUE    = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_ipass;
    logic [3:0]        r_passes;
    logic              r_done;

    // In-flight pipeline: valid, last flag and pass tag of each outstanding read.
    logic [RD_LAT-1:0]      r_sr_v;
    logic [RD_LAT-1:0]      r_sr_last;
    logic [RD_LAT-1:0][3:0] r_sr_pass;

    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [3:0]        r_mem_pass [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [LAT_W-1:0]  w_inflight;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_head_last;
    logic [3:0]        w_head_pass;
    logic              w_final_pop;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + LAT_W'(r_sr_v[i]);
        end
    end

    assign w_valid     = (r_count != '0);
    assign w_push      = r_sr_v[RD_LAT-1];
    assign w_pop       = w_valid & i_ready;
    assign w_head_last = r_mem_last[r_rptr];
    assign w_head_pass = r_mem_pass[r_rptr];
    assign w_final_pop = w_pop & w_head_last & (w_head_pass == r_passes - 4'd1);

    // Every outstanding read is guaranteed a FIFO slot; a pop this cycle
    // frees one slot, hence the "+ pop" on the limit side.
    assign w_issue = (r_state == ST_ISSUE) &&
                     ((32'(r_count) + 32'(w_inflight)) < (32'(FIFO_DEPTH) + 32'(w_pop)));

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_ipass   <= '0;
            r_passes  <= '0;
            r_done    <= 1'b0;
            r_sr_v    <= '0;
            r_sr_last <= '0;
            r_sr_pass <= '0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_final_pop;

            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_sr_v[i]    <= r_sr_v[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
                r_sr_pass[i] <= r_sr_pass[i-1];
            end
            r_sr_v[0]    <= w_issue;
            r_sr_last[0] <= (r_addr == LAST_ADDR);
            r_sr_pass[0] <= r_ipass;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_passes <= (i_passes == 4'd0) ? 4'd1 : i_passes;
                        r_addr   <= '0;
                        r_ipass  <= '0;
                        r_state  <= i_ram_ready ? ST_ISSUE : ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (i_ram_ready) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        if (r_addr == LAST_ADDR) begin
                            r_addr <= '0;
                            if (r_ipass == r_passes - 4'd1) r_state <= ST_DRAIN;
                            else                            r_ipass <= r_ipass + 4'd1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    // The final word leaving the FIFO implies nothing remains
                    // in flight or queued behind it.
                    if (w_final_pop) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= i_ram_data;
            r_mem_last[r_wptr] <= r_sr_last[RD_LAT-1];
            r_mem_pass[r_wptr] <= r_sr_pass[RD_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge s_clk) disable iff (s_rst)
        !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

    assign o_rd_addr  = r_addr;
    assign o_valid    = w_valid;
    assign o_data     = w_valid ? r_mem_data[r_rptr] : '0;
    assign o_last     = w_valid & w_head_last;
    assign o_pass_idx = w_valid ? w_head_pass : 4'd0;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;

endmodule

// File: tb/tb_embed_ram_streamer.sv
// tb_embed_ram_streamer
//   Scoreboard bench: each start pushes the full expected word sequence
//   (frame replayed per pass) into a queue; a negedge monitor pops and
//   compares on every accepted transfer, and checks hold-while-stalled.
module tb_embed_ram_streamer;

    localparam int NW = 8;
    localparam int DW = 64;
    localparam int AW = 12;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [3:0]    i_passes = 4'd0;
    logic          i_ram_ready = 1'b0;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] i_ram_data;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_last;
    logic [3:0]    o_pass_idx;
    logic          o_busy;
    logic          o_done;

    embed_ram_streamer #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .i_passes(i_passes),
        .i_ram_ready(i_ram_ready), .o_rd_addr(o_rd_addr), .i_ram_data(i_ram_data),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    // RAM model: two-cycle read latency, word = {salt, addr}.
    logic [AW-1:0] ram_p1 = '0;
    logic [AW-1:0] ram_p2 = '0;
    logic [31:0]   salt = '0;
    always @(posedge s_clk) begin
        ram_p1 <= o_rd_addr;
        ram_p2 <= ram_p1;
    end
    assign i_ram_data = {salt, 20'd0, ram_p2};

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic [3:0]    p;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_vec = 0;
    int n_err = 0;
    int run_xfers = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ref_cyc = 0;
    int bp_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor / scoreboard consumer
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic [3:0]    prev_p;
    always @(negedge s_clk) begin
        if (s_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(o_valid), 64'(1));
                chk("hold_data", o_data, prev_d);
                chk("hold_last", 64'(o_last), 64'(prev_l));
                chk("hold_pass", 64'(o_pass_idx), 64'(prev_p));
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got data %h, required no word", o_data);
                end else begin
                    e = q.pop_front();
                    chk("data", o_data, e.d);
                    chk("last", 64'(o_last), 64'(e.last));
                    chk("pass_idx", 64'(o_pass_idx), 64'(e.p));
                end
                if (run_xfers == 0) first_cyc = cyc;
                last_cyc = cyc;
                run_xfers++;
            end
            prev_hold = o_valid && !i_ready;
            prev_d = o_data;
            prev_l = o_last;
            prev_p = o_pass_idx;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Consumer ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge s_clk);
            #1;
            case (bp_mode)
                1:       i_ready = 1'($urandom_range(0, 1));
                2:       i_ready = 1'b0;
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Reference model: a frame of NW words per pass, last on the final address.
    task automatic do_start(input int passes, input logic rdy);
        int np;
        @(posedge s_clk);
        #1;
        i_start = 1'b1;
        i_passes = 4'(passes);
        i_ram_ready = rdy;
        salt = $urandom;
        ref_cyc = cyc;
        run_xfers = 0;
        np = (passes == 0) ? 1 : passes;
        for (int p = 0; p < np; p++)
            for (int a = 0; a < NW; a++)
                q.push_back('{d: {salt, 20'd0, 12'(a)}, last: (a == NW - 1), p: 4'(p)});
        @(posedge s_clk);
        #1;
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'(1));
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge s_clk);
            i++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no o_done in %0d cycles, required one", name, budget);
        end
        repeat (3) @(posedge s_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, 64'(o_rd_addr), 64'(0));
        chk({tag, "_valid"}, 64'(o_valid), 64'(0));
        chk({tag, "_last"}, 64'(o_last), 64'(0));
        chk({tag, "_pass_idx"}, 64'(o_pass_idx), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_done"}, 64'(o_done), 64'(0));
        chk({tag, "_data"}, o_data, 64'(0));
    endtask

    task automatic basic_timing(input string tag, input int words);
        chk({tag, "_first_xfer_cycle"}, 64'(first_cyc - ref_cyc), 64'(4));
        chk({tag, "_last_xfer_cycle"}, 64'(last_cyc - ref_cyc), 64'(words + 3));
        chk({tag, "_done_cycle"}, 64'(done_cyc - ref_cyc), 64'(words + 4));
        chk({tag, "_word_count"}, 64'(run_xfers), 64'(words));
        chk({tag, "_queue_empty"}, 64'(q.size()), 64'(0));
    endtask

    initial begin
        int d1;
        int p;
        int k;
        int i;

        // Reset values
        repeat (3) @(posedge s_clk);
        #1;
        chk_reset_outputs("reset");
        s_rst = 1'b0;

        // Basic sweep
        do_start(1, 1'b1);
        chk("first_addr", 64'(o_rd_addr), 64'(0));
        wait_done(100, "basic");
        basic_timing("basic", NW);

        // Gating on i_ram_ready
        do_start(1, 1'b0);
        repeat (9) begin
            @(posedge s_clk);
            #1;
            chk("gate_busy", 64'(o_busy), 64'(1));
            chk("gate_addr", 64'(o_rd_addr), 64'(0));
            chk("gate_valid", 64'(o_valid), 64'(0));
        end
        i_ram_ready = 1'b1;
        k = cyc;
        wait_done(100, "gate");
        chk("gate_first_xfer_cycle", 64'(first_cyc - k), 64'(4));
        chk("gate_done_cycle", 64'(done_cyc - k), 64'(12));
        chk("gate_word_count", 64'(run_xfers), 64'(NW));
        chk("gate_queue_empty", 64'(q.size()), 64'(0));

        // Backpressure with a long stall
        bp_mode = 1;
        do_start(2, 1'b1);
        repeat (12) @(posedge s_clk);
        bp_mode = 2;
        repeat (20) @(posedge s_clk);
        bp_mode = 1;
        wait_done(600, "backpressure");
        chk("bp_word_count", 64'(run_xfers), 64'(2 * NW));
        chk("bp_queue_empty", 64'(q.size()), 64'(0));
        bp_mode = 0;

        // Replay: 3 passes and the 0-means-1 case
        do_start(3, 1'b1);
        wait_done(200, "replay3");
        basic_timing("replay3", 3 * NW);
        do_start(0, 1'b1);
        wait_done(100, "replay0");
        basic_timing("replay0", NW);

        // Random replay counts under random backpressure
        for (int n = 0; n < 4; n++) begin
            bp_mode = 1;
            p = $urandom_range(0, 5);
            do_start(p, 1'b1);
            wait_done(800, "random");
            chk("rand_word_count", 64'(run_xfers), 64'(NW * ((p == 0) ? 1 : p)));
            chk("rand_queue_empty", 64'(q.size()), 64'(0));
        end
        bp_mode = 0;

        // Reset mid-stream
        do_start(2, 1'b1);
        i = 0;
        while (run_xfers < 5 && i < 100) begin
            @(posedge s_clk);
            i++;
        end
        chk("mid_reset_reached_5", 64'(run_xfers >= 5), 64'(1));
        #1;
        s_rst = 1'b1;
        q.delete();
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge s_clk);
        #1;
        s_rst = 1'b0;
        repeat (6) begin
            @(posedge s_clk);
            #1;
            chk("post_reset_valid", 64'(o_valid), 64'(0));
            chk("post_reset_busy", 64'(o_busy), 64'(0));
        end
        do_start(1, 1'b1);
        wait_done(100, "restart");
        basic_timing("restart", NW);

        // Second start during ISSUE is ignored
        do_start(1, 1'b1);
        @(posedge s_clk);
        #1;
        i_start = 1'b1;
        i_passes = 4'd5;
        @(posedge s_clk);
        #1;
        i_start = 1'b0;
        wait_done(100, "ignored");
        d1 = done_cnt;
        repeat (30) @(posedge s_clk);
        #1;
        chk("ignored_single_done", 64'(done_cnt), 64'(d1));
        basic_timing("ignored", NW);
        chk("ignored_busy_idle", 64'(o_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
